// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the dma_bridge block.
//   - dma_state_e      : copy engine state encoding
//   - DMA_ADDRESS      : base of the 7-byte register window in IO space
//   - OFF_*            : register offsets inside the window
//   - CTRL_* / STAT_*  : CTRL write bits and STATUS read bits
//   - DMA_CYCLES_PER_BYTE : copy rate of the RD/CAP/WR loop
//   - in_window()      : window address decode
package dma_pkg;

    localparam logic [15:0] DMA_ADDRESS  = 16'h10C0;
    localparam logic [15:0] DMA_WIN_SIZE = 16'd7;

    localparam logic [2:0] OFF_SRC_L = 3'd0;
    localparam logic [2:0] OFF_SRC_H = 3'd1;
    localparam logic [2:0] OFF_DST_L = 3'd2;
    localparam logic [2:0] OFF_DST_H = 3'd3;
    localparam logic [2:0] OFF_LEN   = 3'd4;
    localparam logic [2:0] OFF_CTRL  = 3'd5;
    localparam logic [2:0] OFF_FILL  = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_FILL   = 3;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_IRQ_EN = 2;

    localparam int DMA_CYCLES_PER_BYTE = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_FIN
    } dma_state_e;

    function automatic logic in_window(input logic [15:0] addr);
        logic [15:0] off;
        off = addr - DMA_ADDRESS;
        return (off < DMA_WIN_SIZE);
    endfunction

endpackage

// File: rtl/dma_regfile.sv
// dma_regfile: register window of dma_bridge.
//   Decodes the 7-byte window, stores SRC/DST/LEN/FILL, keeps the sticky
//   done bit and irq_en, and returns register reads one cycle late.
// Ports:
//   clk, rst            : clock, async active-low reset
//   cpu_*               : CPU data port (address, write data, strobes)
//   mem_dout            : memory read data, returned when no window read
//   busy, set_done      : engine status from the FSM
//   win_hit             : current CPU address falls in the window
//   cpu_dout            : read data back to the CPU
//   start_p, abort_p    : single-cycle commands to the FSM
//   src, dst, len       : values loaded by the FSM on start (len 1..256)
//   fill_req, fill_byte : fill command and pattern (DMA_FILL_EN only)
//   irq_en              : completion pulse enable
// Build option: DMA_FILL_EN adds the FILL register and fill request.
module dma_regfile
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_w_en,
    input  logic        cpu_r_en,
    input  logic [7:0]  mem_dout,
    input  logic        busy,
    input  logic        set_done,
    output logic        win_hit,
    output logic [7:0]  cpu_dout,
    output logic        start_p,
    output logic        abort_p,
    output logic [15:0] src,
    output logic [15:0] dst,
    output logic [8:0]  len,
`ifdef DMA_FILL_EN
    output logic        fill_req,
    output logic [7:0]  fill_byte,
`endif
    output logic        irq_en
);

    logic [7:0] src_l_q, src_l_d, src_h_q, src_h_d;
    logic [7:0] dst_l_q, dst_l_d, dst_h_q, dst_h_d;
    logic [7:0] len_q, len_d, fill_q, fill_d;
    logic       irq_en_q, irq_en_d, done_q, done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [2:0] off;
    logic       wr_hit, rd_hit, wr_ctrl;

    assign win_hit = in_window(cpu_address);
    assign off     = 3'(cpu_address - DMA_ADDRESS);
    assign wr_hit  = cpu_w_en & win_hit;
    assign rd_hit  = cpu_r_en & win_hit;
    assign wr_ctrl = wr_hit & (off == OFF_CTRL);

    // Abort in the same write as start cancels the start.
    assign start_p = wr_ctrl & cpu_din[CTRL_START] & ~cpu_din[CTRL_ABORT] & ~busy;
    assign abort_p = wr_ctrl & cpu_din[CTRL_ABORT] & busy;

    assign src    = {src_h_q, src_l_q};
    assign dst    = {dst_h_q, dst_l_q};
    assign len    = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
    assign irq_en = irq_en_q;
`ifdef DMA_FILL_EN
    assign fill_req  = cpu_din[CTRL_FILL];
    assign fill_byte = fill_q;
`endif

    assign cpu_dout = rd_valid_q ? rd_data_q : mem_dout;

    always_comb begin
        src_l_d    = src_l_q;
        src_h_d    = src_h_q;
        dst_l_d    = dst_l_q;
        dst_h_d    = dst_h_q;
        len_d      = len_q;
        fill_d     = fill_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        rd_valid_d = rd_hit;
        rd_data_d  = 8'h00;

        if (wr_hit && !busy) begin
            case (off)
                OFF_SRC_L: src_l_d = cpu_din;
                OFF_SRC_H: src_h_d = cpu_din;
                OFF_DST_L: dst_l_d = cpu_din;
                OFF_DST_H: dst_h_d = cpu_din;
                OFF_LEN:   len_d   = cpu_din;
`ifdef DMA_FILL_EN
                OFF_FILL:  fill_d  = cpu_din;
`endif
                default: ;
            endcase
        end
        if (wr_ctrl) irq_en_d = cpu_din[CTRL_IRQ_EN];

        if (start_p)                          done_d = 1'b0;
        else if (set_done)                    done_d = 1'b1;
        else if (rd_hit && off == OFF_CTRL)   done_d = 1'b0;

        if (rd_hit) begin
            case (off)
                OFF_SRC_L: rd_data_d = src_l_q;
                OFF_SRC_H: rd_data_d = src_h_q;
                OFF_DST_L: rd_data_d = dst_l_q;
                OFF_DST_H: rd_data_d = dst_h_q;
                OFF_LEN:   rd_data_d = len_q;
                OFF_CTRL:  rd_data_d = {5'b0, irq_en_q, done_q, busy};
                OFF_FILL:  rd_data_d = fill_q;
                default:   rd_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_l_q    <= 8'h00;
            src_h_q    <= 8'h00;
            dst_l_q    <= 8'h00;
            dst_h_q    <= 8'h00;
            len_q      <= 8'h00;
            fill_q     <= 8'h00;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            src_l_q    <= src_l_d;
            src_h_q    <= src_h_d;
            dst_l_q    <= dst_l_d;
            dst_h_q    <= dst_h_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: rtl/dma_bridge.sv
// dma_bridge: single-channel DMA engine in front of d_ram_and_io.
//   Idle: CPU accesses pass straight through to mem_*, except the
//   register window which is served locally. Busy: the engine owns the
//   bus, copies LEN bytes SRC->DST and stalls non-window CPU accesses.
// Ports:
//   clk, rst       : clock, async active-low reset
//   cpu_*          : CPU data port; cpu_dout read data, cpu_stall hold
//   mem_*          : bus toward d_ram_and_io
//   done_flag      : one-cycle completion pulse (when irq_en)
// Build option: DMA_FILL_EN adds fill mode (WR-only loop writing FILL).
//
// state | meaning
// IDLE  | pass-through, waiting for start
// RD    | read strobe at src
// CAP   | read strobe held at src, capture mem_dout into buffer
// WR    | write buffer (or FILL) to dst, advance pointers and count
// FIN   | set done, pulse done_flag if enabled
module dma_bridge
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_w_en,
    input  logic        cpu_r_en,
    output logic [7:0]  cpu_dout,
    output logic        cpu_stall,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_din,
    output logic        mem_w_en,
    output logic        mem_r_en,
    input  logic [7:0]  mem_dout,
    output logic        done_flag
);

    dma_state_e  state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  buf_q, buf_d;
    logic        busy, win_hit, start_p, abort_p, irq_en;
    logic [15:0] reg_src, reg_dst;
    logic [8:0]  reg_len;
`ifdef DMA_FILL_EN
    logic        fill_req, fill_run_q, fill_run_d;
    logic [7:0]  fill_byte;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign cpu_stall = busy & (cpu_r_en | cpu_w_en) & ~win_hit;

    dma_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .cpu_address (cpu_address),
        .cpu_din     (cpu_din),
        .cpu_w_en    (cpu_w_en),
        .cpu_r_en    (cpu_r_en),
        .mem_dout    (mem_dout),
        .busy        (busy),
        .set_done    (state_q == ST_FIN),
        .win_hit     (win_hit),
        .cpu_dout    (cpu_dout),
        .start_p     (start_p),
        .abort_p     (abort_p),
        .src         (reg_src),
        .dst         (reg_dst),
        .len         (reg_len),
`ifdef DMA_FILL_EN
        .fill_req    (fill_req),
        .fill_byte   (fill_byte),
`endif
        .irq_en      (irq_en)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        mem_address = cpu_address;
        mem_din     = cpu_din;
        mem_w_en    = 1'b0;
        mem_r_en    = 1'b0;
        done_flag   = 1'b0;
`ifdef DMA_FILL_EN
        fill_run_d  = fill_run_q;
`endif

        case (state_q)
            ST_IDLE: begin
                mem_w_en = cpu_w_en & ~win_hit;
                mem_r_en = cpu_r_en & ~win_hit;
                if (start_p) begin
                    src_d   = reg_src;
                    dst_d   = reg_dst;
                    cnt_d   = reg_len;
                    state_d = ST_RD;
`ifdef DMA_FILL_EN
                    fill_run_d = fill_req;
                    if (fill_req) state_d = ST_WR;
`endif
                end
            end
            ST_RD: begin
                mem_address = src_q;
                mem_r_en    = 1'b1;
                state_d     = ST_CAP;
            end
            ST_CAP: begin
                mem_address = src_q;
                mem_r_en    = 1'b1;
                buf_d       = mem_dout;
                state_d     = ST_WR;
            end
            ST_WR: begin
                mem_address = dst_q;
                mem_din     = buf_q;
                mem_w_en    = 1'b1;
                dst_d       = dst_q + 16'd1;
                src_d       = src_q + 16'd1;
                cnt_d       = cnt_q - 9'd1;
                state_d     = (cnt_q == 9'd1) ? ST_FIN : ST_RD;
`ifdef DMA_FILL_EN
                if (fill_run_q) begin
                    mem_din = fill_byte;
                    src_d   = src_q;
                    if (cnt_q != 9'd1) state_d = ST_WR;
                end
`endif
            end
            ST_FIN: begin
                done_flag = irq_en;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any write on the bus this cycle still completes; only the
        // following state is cancelled.
        if (abort_p) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            src_q   <= 16'h0000;
            dst_q   <= 16'h0000;
            cnt_q   <= 9'd0;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

`ifdef DMA_FILL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fill_run_q <= 1'b0;
        else      fill_run_q <= fill_run_d;
    end
`endif

endmodule

// File: tb/tb_dma_bridge.sv
// Directed bench for dma_bridge with a synchronous-read memory model.
module tb_dma_bridge;
    import dma_pkg::*;

    localparam logic [15:0] A_SRC_L = 16'h10C0;
    localparam logic [15:0] A_SRC_H = 16'h10C1;
    localparam logic [15:0] A_DST_L = 16'h10C2;
    localparam logic [15:0] A_DST_H = 16'h10C3;
    localparam logic [15:0] A_LEN   = 16'h10C4;
    localparam logic [15:0] A_CTRL  = 16'h10C5;
    localparam logic [15:0] A_FILL  = 16'h10C6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_address = 16'h0000;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_w_en = 1'b0, cpu_r_en = 1'b0;
    logic [7:0]  cpu_dout;
    logic        cpu_stall;
    logic [15:0] mem_address;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_w_en, mem_r_en, done_flag;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata = 8'h00;
    int          n_checks = 0, n_fail = 0, done_cnt = 0;

    always #5 clk = ~clk;

    dma_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_address(cpu_address), .cpu_din(cpu_din),
        .cpu_w_en(cpu_w_en), .cpu_r_en(cpu_r_en),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .mem_address(mem_address), .mem_din(mem_din),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .mem_dout(mem_dout), .done_flag(done_flag)
    );

    assign mem_dout = rdata;
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_address] <= mem_din;
        if (mem_r_en) rdata <= mem[mem_address];
    end
    always @(negedge clk) if (done_flag) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_address = a; cpu_din = d; cpu_w_en = 1'b1; cpu_r_en = 1'b0;
        tick();
        cpu_w_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic stall);
        cpu_address = a; cpu_r_en = 1'b1; cpu_w_en = 1'b0;
        #1 stall = cpu_stall;
        tick();
        cpu_r_en = 1'b0;
        d = cpu_dout;
    endtask

    task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        wr(A_SRC_L, s[7:0]); wr(A_SRC_H, s[15:8]);
        wr(A_DST_L, d[7:0]); wr(A_DST_H, d[15:8]);
        wr(A_LEN, n);
    endtask

    // Called in cycle 1 after start; returns the cycle of the first pulse or -1.
    task automatic run_until_done(input int max, output int fin);
        fin = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (done_flag) begin fin = c; break; end
            @(posedge clk); #1;
        end
        if (fin >= 0) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s;
        int         fin, n, errs, dc0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset values
        #3;
        chk("rst_done_flag", done_flag, 1'b0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        chk("rst_cpu_dout", cpu_dout, 8'h00);
        chk("rst_mem_w_en", mem_w_en, 1'b0);
        #18 rst = 1'b1;
        tick();

        // Pass-through write then read
        cpu_address = 16'h0010; cpu_din = 8'h5A; cpu_w_en = 1'b1;
        #1;
        chk("pt_mem_address", mem_address, 16'h0010);
        chk("pt_mem_din", mem_din, 8'h5A);
        chk("pt_mem_w_en", mem_w_en, 1'b1);
        chk("pt_stall", cpu_stall, 1'b0);
        tick(); cpu_w_en = 1'b0;
        rd(16'h0010, d, s);
        chk("pt_read_data", d, 8'h5A);

        // Window write is not forwarded
        cpu_address = A_LEN; cpu_din = 8'h09; cpu_w_en = 1'b1;
        #1 chk("win_no_fwd", mem_w_en, 1'b0);
        tick(); cpu_w_en = 1'b0;
        rd(A_LEN, d, s);
        chk("len_readback", d, 8'h09);

        // FILL register exists only with the fill build
        wr(A_FILL, 8'h20);
        rd(A_FILL, d, s);
`ifdef DMA_FILL_EN
        chk("fill_readback", d, 8'h20);
`else
        chk("fill_readback", d, 8'h00);
`endif

        // 4-byte copy with irq
        mem[16'h0100] = 8'hA1; mem[16'h0101] = 8'hB2;
        mem[16'h0102] = 8'hC3; mem[16'h0103] = 8'hD4;
        set_regs(16'h0100, 16'h2000, 8'd4);
        dc0 = done_cnt;
        wr(A_CTRL, 8'h03);
        run_until_done(40, fin);
        chk("copy_fin_cycle", fin, 13);
        repeat (5) tick();
        chk("copy_pulses", done_cnt - dc0, 1);
        chk("copy_b0", mem[16'h2000], 8'hA1);
        chk("copy_b1", mem[16'h2001], 8'hB2);
        chk("copy_b2", mem[16'h2002], 8'hC3);
        chk("copy_b3", mem[16'h2003], 8'hD4);
        chk("copy_no_extra", mem[16'h2004], 8'h00);
        rd(A_CTRL, d, s);
        chk("copy_status", d, 8'h06);
        rd(A_CTRL, d, s);
        chk("status_done_cleared", d, 8'h04);

        // Stall while busy; register writes ignored while busy
        set_regs(16'h0100, 16'h2100, 8'd2);
        wr(A_CTRL, 8'h01);
        wr(A_SRC_L, 8'hEE);
        cpu_address = 16'h0000; cpu_r_en = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!cpu_stall) break;
            n++;
            tick();
        end
        chk("stall_cycles", n, 6);
        chk("fwd_after_idle", mem_r_en, 1'b1);
        tick(); cpu_r_en = 1'b0;
        rd(A_SRC_L, d, s);
        chk("busy_write_ignored", d, 8'h00);
        chk("stall_copy_b0", mem[16'h2100], 8'hA1);
        chk("stall_copy_b1", mem[16'h2101], 8'hB2);

        // STATUS poll during busy is served without stall
        set_regs(16'h0100, 16'h2180, 8'd2);
        wr(A_CTRL, 8'h01);
        rd(A_CTRL, d, s);
        chk("poll_no_stall", s, 1'b0);
        chk("poll_status", d, 8'h01);
        repeat (10) tick();

        // LEN=0 (256 bytes) with source wrap
        mem[16'hFFFF] = 8'hC3;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        set_regs(16'hFFFF, 16'h3000, 8'd0);
        wr(A_CTRL, 8'h03);
        run_until_done(900, fin);
        chk("wrap_fin_cycle", fin, 769);
        chk("wrap_first", mem[16'h3000], 8'hC3);
        chk("wrap_second", mem[16'h3001], 8'h5A);
        errs = 0;
        for (int k = 1; k < 256; k++)
            if (mem[16'h3000 + 16'(k)] !== (8'(k - 1) ^ 8'h5A)) errs++;
        chk("wrap_block_errors", errs, 0);
        chk("wrap_no_extra", mem[16'h3100], 8'h00);

        // Abort at cycle 5 of an 8-byte copy
        for (int i = 0; i < 8; i++) mem[16'h0200 + 16'(i)] = 8'h70 + 8'(i);
        set_regs(16'h0200, 16'h2200, 8'd8);
        dc0 = done_cnt;
        wr(A_CTRL, 8'h03);
        repeat (4) tick();
        wr(A_CTRL, 8'h06);
        rd(A_CTRL, d, s);
        chk("abort_status", d, 8'h04);
        repeat (30) tick();
        chk("abort_no_pulse", done_cnt - dc0, 0);
        chk("abort_b0", mem[16'h2200], 8'h70);
        chk("abort_b2_unwritten", mem[16'h2202], 8'h00);

        // Start and abort together: abort wins
        set_regs(16'h0200, 16'h2280, 8'd2);
        wr(A_CTRL, 8'h05);
        rd(A_CTRL, d, s);
        chk("start_abort_status", d, 8'h00);
        repeat (10) tick();
        chk("start_abort_nowrite", mem[16'h2280], 8'h00);

`ifdef DMA_FILL_EN
        // Fill mode
        for (int i = 0; i < 96; i++) mem[16'h2000 + 16'(i)] = 8'h00;
        wr(A_FILL, 8'h20);
        set_regs(16'h0000, 16'h2000, 8'd80);
        wr(A_CTRL, 8'h0B);
        run_until_done(200, fin);
        chk("fill_fin_cycle", fin, 81);
        errs = 0;
        for (int i = 0; i < 80; i++)
            if (mem[16'h2000 + 16'(i)] !== 8'h20) errs++;
        chk("fill_block_errors", errs, 0);
        chk("fill_no_extra", mem[16'h2050], 8'h00);
`endif

        // Async reset mid-transfer drops strobes at once
        set_regs(16'h0100, 16'h2300, 8'd4);
        wr(A_CTRL, 8'h01);
        #1 chk("mid_rd_strobe", mem_r_en, 1'b1);
        rst = 1'b0;
        #1 chk("rst_drops_strobe", mem_r_en, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rd(A_LEN, d, s);
        chk("rst_len_cleared", d, 8'h00);
        rd(A_CTRL, d, s);
        chk("rst_status", d, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
